// File: rtl/dg0045_prog_rom_responder.sv
// ============================================================================
// dg0045_prog_rom_responder
// ----------------------------------------------------------------------------
// ROM-side responder for the DG0045 core's multiplexed instruction-fetch port.
//
// The core presents its 10-bit fetch address {PU[3:0],PL[5:0]} on a 5-bit
// PC_HL bus in two halves, selected by PC_MUX. This block drives PC_MUX,
// captures the high half, and returns the addressed byte from a writable
// program store on the core's mainROM input inside the core's fetch window.
// A valid/ready byte loader fills the store while the core is held frozen
// through cpu_run.
//
// Ports
//   clk_in      in   1   shared core clock, all state on posedge
//   RESET       in   1   asynchronous, active-low
//   i_ena       in   1   system enable (core ena = i_ena & o_cpu_run)
//   o_cpu_run   out  1   core enable qualifier (high only in RUN)
//   i_pc_hl     in   5   core PC_HL bus
//   o_pc_mux    out  1   1 = core drives {PU,PL[5]}, 0 = core drives PL[4:0]
//   o_rom_data  out  8   instruction byte to core mainROM input
//   i_ld_start  in   1   pulse: begin/restart a load at address 0
//   i_ld_valid  in   1   i_ld_data holds a byte
//   o_ld_ready  out  1   loader accepts a byte this cycle (LOAD state)
//   i_ld_data   in   8   program byte
//   i_ld_last   in   1   qualifies i_ld_valid: final byte of the image
//   i_run_go    in   1   pulse: start/resume the core without reloading
//   o_ld_done   out  1   one-cycle pulse in the first cycle after a load
//   o_ld_count  out  11  bytes written in the current/last load
//   o_ph        out  3   phase counter, mirrors the core's clock divider
// ============================================================================
module dg0045_prog_rom_responder #(
  parameter int          ADDR_W  = 10,
  parameter int          DEPTH   = 1024,
  parameter logic [7:0]  IDLE_OP = 8'h00
) (
  input  logic              clk_in,
  input  logic              RESET,
  input  logic              i_ena,
  output logic              o_cpu_run,
  input  logic [4:0]        i_pc_hl,
  output logic              o_pc_mux,
  output logic [7:0]        o_rom_data,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [7:0]        i_ld_data,
  input  logic              i_ld_last,
  input  logic              i_run_go,
  output logic              o_ld_done,
  output logic [ADDR_W:0]   o_ld_count,
  output logic [2:0]        o_ph
);

  localparam int                MEM_AW    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_ADDR = MEM_AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;

  logic [2:0]          r_ph;
  logic [4:0]          r_hi;
  logic [7:0]          r_rom_hold;
  logic [MEM_AW-1:0]   r_ld_addr;
  logic [ADDR_W:0]     r_ld_count;
  logic                r_ld_done;

  // Program store: deliberately has no reset so an aborted load keeps the
  // bytes already written.
  logic [7:0]          r_mem [DEPTH];

  logic                w_cpu_run;
  logic                w_ld_ready;
  logic                w_ld_done_nxt;
  logic                w_wr;
  logic                w_full;
  logic                w_advance;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic [ADDR_W:0]     w_fetch_ext;
  logic [7:0]          w_rd_data;
  logic [7:0]          w_rom;

  // --------------------------------------------------------------------------
  // Fetch address and asynchronous store read
  // --------------------------------------------------------------------------
  // During ph==3 the core drives PL[4:0]; the high half was captured at the
  // end of ph==2, so the full address is available combinationally.
  assign w_fetch_addr = ADDR_W'({r_hi, i_pc_hl});
  assign w_fetch_ext  = {1'b0, w_fetch_addr};
  assign w_rd_data    = (w_fetch_ext < DEPTH_EXT) ? r_mem[w_fetch_addr[MEM_AW-1:0]]
                                                  : IDLE_OP;

  assign w_full    = (r_ld_addr == LAST_ADDR);
  // The phase counter only moves on edges where the core itself advances.
  assign w_advance = (r_state == S_RUN) && i_ena;

  // --------------------------------------------------------------------------
  // FSM next-state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cpu_run     = 1'b0;
    w_ld_ready    = 1'b0;
    w_ld_done_nxt = 1'b0;
    w_wr          = 1'b0;
    unique case (r_state)
      S_HALT: begin
        // ld_start has priority over run_go.
        if (i_ld_start) begin
          w_state_nxt = S_LOAD;
        end else if (i_run_go) begin
          w_state_nxt = S_RUN;
        end
      end
      S_LOAD: begin
        w_ld_ready = 1'b1;
        if (i_ld_start) begin
          // Restart: a byte presented alongside ld_start is dropped.
          w_state_nxt = S_LOAD;
        end else if (i_ld_valid) begin
          w_wr = 1'b1;
          if (i_ld_last || w_full) begin
            w_state_nxt   = S_RUN;
            w_ld_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        w_cpu_run = 1'b1;
        if (i_ld_start) begin
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Phase counter, fetch capture and rom_data hold
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      r_ph       <= 3'd0;
      r_hi       <= 5'd0;
      r_rom_hold <= IDLE_OP;
    end else begin
      if (w_advance) begin
        r_ph <= r_ph + 3'd1;
        if (r_ph == 3'd2) begin
          r_hi <= i_pc_hl;
        end
        // Keep the byte the core just sampled on the bus for ph 4..7,0..2.
        if (r_ph == 3'd3) begin
          r_rom_hold <= w_rd_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Loader address/count and completion pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      r_ld_addr  <= '0;
      r_ld_count <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= w_ld_done_nxt;
      // ld_start enters or restarts LOAD from every state.
      if (i_ld_start) begin
        r_ld_addr  <= '0;
        r_ld_count <= '0;
      end else if (w_wr) begin
        r_ld_count <= r_ld_count + (ADDR_W + 1)'(1);
        // Never wrap: the final slot write also ends the load.
        if (!w_full) begin
          r_ld_addr <= r_ld_addr + MEM_AW'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Program store write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_mem[r_ld_addr] <= i_ld_data;
    end
  end

  // --------------------------------------------------------------------------
  // rom_data: live read in ph==3, held value otherwise, no-op outside RUN
  // --------------------------------------------------------------------------
  always_comb begin
    w_rom = IDLE_OP;
    if (r_state == S_RUN) begin
      w_rom = (r_ph == 3'd3) ? w_rd_data : r_rom_hold;
    end
  end

  assign o_cpu_run  = w_cpu_run;
  assign o_ld_ready = w_ld_ready;
  assign o_pc_mux   = (r_state == S_RUN) && (r_ph == 3'd2);
  assign o_rom_data = w_rom;
  assign o_ld_done  = r_ld_done;
  assign o_ld_count = r_ld_count;
  assign o_ph       = r_ph;

endmodule
